// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction LED controller and its display driver.
// Holds the FSM state encoding and the default timing constants. The default
// timing assumes a 50 MHz clock and a 1 ms tick.
package reaction_pkg;

  // State codes are visible on the debug/display port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_GO   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int N_PLAYERS_DEF = 2;
  localparam int TICK_DIV_DEF  = 50000;
  localparam int DLY_MIN_DEF   = 1000;
  localparam int DLY_MAX_DEF   = 6000;
  localparam int TIMEOUT_DEF   = 2000;
  localparam int CNT_W_DEF     = 13;

endpackage

// File: rtl/reaction_led_ctrl_tick_prescaler.sv
// tick_prescaler: divides clk down to the timing tick.
// The counter runs 0..TICK_DIV-1. tick is high for exactly one cycle, on the
// cycle the counter holds TICK_DIV-1. clr restarts the count at 0 on the
// next cycle.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - synchronous counter clear
//   tick - one-cycle tick pulse
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reaction_led_ctrl.sv
// reaction_led_ctrl: multi-player reaction timer.
// The controller draws a pseudo-random wait from a free-running seed counter
// and lights GO when that wait expires. It then arbitrates the player presses.
// It flags false starts, the winner(s) and a timeout, and it reports the
// reaction time in ticks.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start, abort - single-cycle control pulses (abort has priority)
//   press        - single-cycle press pulse per player
//   led_go       - GO indicator (high while in GO)
//   led_win      - per-player winner flags
//   led_false    - per-player false-start flags
//   led_timeout  - no press within TIMEOUT ticks of GO
//   rt_ticks     - reaction time of the winning press
//   busy         - high in ARM/WAIT/GO
//   state        - current state code
module reaction_led_ctrl
  import reaction_pkg::*;
#(
  parameter int N_PLAYERS = N_PLAYERS_DEF,
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DLY_MIN   = DLY_MIN_DEF,
  parameter int DLY_MAX   = DLY_MAX_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_PLAYERS-1:0] press,
  output logic                 led_go,
  output logic [N_PLAYERS-1:0] led_win,
  output logic [N_PLAYERS-1:0] led_false,
  output logic                 led_timeout,
  output logic [CNT_W-1:0]     rt_ticks,
  output logic                 busy,
  output logic [2:0]           state
);

  localparam logic [CNT_W-1:0] DLY_MIN_C = CNT_W'(DLY_MIN);
  localparam logic [CNT_W-1:0] DLY_MAX_C = CNT_W'(DLY_MAX);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TIMEOUT_X = (CNT_W+1)'(TIMEOUT);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     seed_q, seed_d;
  logic [CNT_W-1:0]     delay_q, delay_d;
  logic [CNT_W-1:0]     tcnt_q, tcnt_d;
  logic [CNT_W-1:0]     rt_q, rt_d;
  logic [N_PLAYERS-1:0] win_q, win_d;
  logic [N_PLAYERS-1:0] false_q, false_d;
  logic                 tout_q, tout_d;

  logic             tick;
  logic             any_press;
  logic [CNT_W:0]   tcnt_inc;
  logic             wait_done;
  logic             go_tmo;

  function automatic logic [CNT_W-1:0] next_seed(input logic [CNT_W-1:0] s);
    return (s >= DLY_MAX_C) ? DLY_MIN_C : s + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  // Any state change restarts the tick phase, so each interval begins on a
  // full tick period.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_d != state_q),
    .tick (tick)
  );

  assign any_press = |press;
  // The extra bit keeps the compare exact even when the counter is all ones.
  assign tcnt_inc  = {1'b0, tcnt_q} + 1'b1;
  // The transition happens on the tick that makes the count reach its limit,
  // so the new state starts on the following cycle.
  assign wait_done = tick && (tcnt_inc == {1'b0, delay_q});
  assign go_tmo    = tick && (tcnt_inc == TIMEOUT_X);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) state_d = ST_ARM;
        ST_ARM:  state_d = ST_WAIT;
        ST_WAIT: begin
          if (any_press)      state_d = ST_DONE;
          else if (wait_done) state_d = ST_GO;
        end
        ST_GO: begin
          if (any_press || go_tmo) state_d = ST_DONE;
        end
        ST_DONE: if (start) state_d = ST_ARM;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    led_go = (state_q == ST_GO);
    busy   = (state_q == ST_ARM) || (state_q == ST_WAIT) || (state_q == ST_GO);
    state  = state_q;
  end

  assign led_win     = win_q;
  assign led_false   = false_q;
  assign led_timeout = tout_q;
  assign rt_ticks    = rt_q;

  // Datapath next-state: seed, delay, tick counter and indicators
  always_comb begin
    seed_d  = seed_q;
    delay_d = delay_q;
    tcnt_d  = tcnt_q;
    rt_d    = rt_q;
    win_d   = win_q;
    false_d = false_q;
    tout_d  = tout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        seed_d = next_seed(seed_q);
        // The delay captures the seed on the cycle start is accepted. ARM
        // then holds it while the seed counter is frozen.
        if (start) delay_d = seed_q;
      end
      ST_ARM: begin
        tcnt_d  = '0;
        rt_d    = '0;
        win_d   = '0;
        false_d = '0;
        tout_d  = 1'b0;
      end
      ST_WAIT: begin
        if (any_press)      false_d = press;
        else if (wait_done) tcnt_d  = '0;
        else if (tick)      tcnt_d  = sat_inc(tcnt_q);
      end
      ST_GO: begin
        if (any_press) begin
          win_d = press;
          rt_d  = tcnt_q;
        end else if (go_tmo) begin
          tout_d = 1'b1;
          rt_d   = TIMEOUT_C;
        end else if (tick) begin
          tcnt_d = sat_inc(tcnt_q);
        end
      end
      default: ;
    endcase

    // Entering IDLE blanks every indicator. The seed keeps running.
    if (abort) begin
      tcnt_d  = '0;
      rt_d    = '0;
      win_d   = '0;
      false_d = '0;
      tout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q  <= DLY_MIN_C;
      delay_q <= DLY_MIN_C;
      tcnt_q  <= '0;
      rt_q    <= '0;
      win_q   <= '0;
      false_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      seed_q  <= seed_d;
      delay_q <= delay_d;
      tcnt_q  <= tcnt_d;
      rt_q    <= rt_d;
      win_q   <= win_d;
      false_q <= false_d;
      tout_q  <= tout_d;
    end
  end

endmodule
